// File: rtl/less_distance_pkg.sv
// Shared types for the nearest-distance unit.
//   DIST_WIDTH : default operand/distance width
//   dist_t     : one unsigned distance/operand word
package less_distance_pkg;
  localparam int DIST_WIDTH = 8;
  typedef logic [DIST_WIDTH-1:0] dist_t;
endpackage

// File: rtl/less_distance_unit_abs_diff.sv
// abs_diff: combinational |x - y| for unsigned operands.
//   x_i, y_i : WIDTH-bit unsigned operands
//   d_o      : WIDTH-bit absolute difference
// Built as a ripple borrow subtractor followed by a conditional
// two's-complement negate (invert + ripple increment) when x < y.
module abs_diff
  import less_distance_pkg::*;
#(
  parameter int WIDTH = DIST_WIDTH
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] d_o
);
  logic [WIDTH:0]   bw;   // borrow chain; bw[WIDTH] is the sign of x - y
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] inv;
  logic [WIDTH-1:0] cy;   // increment carry chain
  logic             neg;

  assign bw[0] = 1'b0;
  assign neg   = bw[WIDTH];
  assign cy[0] = neg;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sub
    assign raw[i]  = x_i[i] ^ y_i[i] ^ bw[i];
    assign bw[i+1] = (~x_i[i] & y_i[i]) | (~(x_i[i] ^ y_i[i]) & bw[i]);
    assign inv[i]  = raw[i] ^ neg;
    assign d_o[i]  = inv[i] ^ cy[i];
  end

  for (genvar i = 1; i < WIDTH; i++) begin : g_inc
    assign cy[i] = inv[i-1] & cy[i-1];
  end
endmodule

// File: rtl/less_distance_unit_bhv.sv
// less_distance_unit_bhv: behavioural twin of less_distance_unit.
// Same ports and timing; cycle-identical to the structural netlist.
//   clk, rst_n, reff, aa, bb, diff, sel_b : as in less_distance_unit
module less_distance_unit_bhv
  import less_distance_pkg::*;
#(
  parameter int WIDTH = DIST_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] reff,
  input  logic [WIDTH-1:0] aa,
  input  logic [WIDTH-1:0] bb,
  output logic [WIDTH-1:0] diff,
  output logic             sel_b
);
  logic [WIDTH:0]   sa, sb;   // WIDTH+1-bit raw differences, MSB = borrow
  logic [WIDTH-1:0] da, db;

  assign sa = {1'b0, reff} - {1'b0, aa};
  assign sb = {1'b0, reff} - {1'b0, bb};
  assign da = sa[WIDTH] ? (aa - reff) : sa[WIDTH-1:0];
  assign db = sb[WIDTH] ? (bb - reff) : sb[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff  <= '0;
      sel_b <= 1'b0;
    end else begin
      diff  <= (db < da) ? db : da;
      sel_b <= (db < da);
    end
  end
endmodule

// File: rtl/less_distance_unit.sv
// less_distance_unit: registered nearest-distance unit (structural).
//   clk, rst_n : rising-edge clock, async active-low reset
//   reff       : reference value (unsigned)
//   aa, bb     : candidate operands (unsigned)
//   diff       : registered min(|reff-aa|, |reff-bb|)
//   sel_b      : registered, 1 when B is strictly closer (ties pick A)
module less_distance_unit
  import less_distance_pkg::*;
#(
  parameter int WIDTH = DIST_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] reff,
  input  logic [WIDTH-1:0] aa,
  input  logic [WIDTH-1:0] bb,
  output logic [WIDTH-1:0] diff,
  output logic             sel_b
);
  logic [WIDTH-1:0] da, db;
  logic [WIDTH:0]   cb;       // borrow chain of db - da
  logic [WIDTH-1:0] diff_d, diff_q;
  logic             sel_d, sel_q;

  abs_diff #(.WIDTH(WIDTH)) u_abs_a (.x_i(reff), .y_i(aa), .d_o(da));
  abs_diff #(.WIDTH(WIDTH)) u_abs_b (.x_i(reff), .y_i(bb), .d_o(db));

  // Magnitude compare: borrow out of db - da means db < da.
  assign cb[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cmp
    assign cb[i+1] = (~db[i] & da[i]) | (~(db[i] ^ da[i]) & cb[i]);
  end

  assign sel_d  = cb[WIDTH];
  assign diff_d = sel_d ? db : da;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
      sel_q  <= 1'b0;
    end else begin
      diff_q <= diff_d;
      sel_q  <= sel_d;
    end
  end

  assign diff  = diff_q;
  assign sel_b = sel_q;
endmodule

// File: tb/tb_less_distance_unit.sv
// Bench for less_distance_unit and its behavioural twin: directed
// vectors, random triples against a min-abs reference, async reset.
module tb_less_distance_unit;
  localparam int W = 8;

  logic         clk, rst_n;
  logic [W-1:0] reff, aa, bb;
  logic [W-1:0] diff_s, diff_b;
  logic         sel_s, sel_bh;

  int errors = 0;
  int checks = 0;

  less_distance_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .reff(reff), .aa(aa), .bb(bb),
    .diff(diff_s), .sel_b(sel_s)
  );

  less_distance_unit_bhv #(.WIDTH(W)) bhv (
    .clk(clk), .rst_n(rst_n), .reff(reff), .aa(aa), .bb(bb),
    .diff(diff_b), .sel_b(sel_bh)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer distances, ties go to A.
  function automatic void golden(input int r, input int a, input int b,
                                 output int d, output int s);
    int da, db;
    da = (r > a) ? r - a : a - r;
    db = (r > b) ? r - b : b - r;
    s  = (db < da) ? 1 : 0;
    d  = (db < da) ? db : da;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Check both models' outputs against an expected pair.
  task automatic chk_out(input string tag, input int d, input int s);
    chk({tag, ".diff_str"}, int'(diff_s), d);
    chk({tag, ".sel_str"},  int'(sel_s),  s);
    chk({tag, ".diff_bhv"}, int'(diff_b), d);
    chk({tag, ".sel_bhv"},  int'(sel_bh), s);
  endtask

  // Drive a triple at the falling edge, check just after the next rising edge.
  task automatic step(input string tag, input int r, input int a, input int b);
    int d, s;
    @(negedge clk);
    reff = W'(r); aa = W'(a); bb = W'(b);
    golden(r, a, b, d, s);
    @(posedge clk);
    #1;
    chk_out(tag, d, s);
  endtask

  initial begin
    int r, a, b;
    rst_n = 1'b1;
    reff = 8'hA5; aa = 8'h3C; bb = 8'h77;

    // Async reset mid-cycle: no clock edge between assertion and check.
    #2 rst_n = 1'b0;
    #1 chk_out("rst_async", 0, 0);
    @(posedge clk); #1;
    chk_out("rst_hold", 0, 0);

    @(negedge clk);
    rst_n = 1'b1;
    reff = '0; aa = '0; bb = '0;
    @(posedge clk); #1;
    chk_out("rst_first", 0, 0);

    step("b_closer", 8'hDB, 8'h05, 8'hE3);
    chk("b_closer.lit", int'(diff_s), 8);
    step("a_closer", 8'h6F, 8'h56, 8'h35);
    chk("a_closer.lit", int'(diff_s), 8'h19);
    step("tie",      100,   90,    110);
    chk("tie.lit_sel", int'(sel_s), 0);
    step("ext0",     8'h00, 8'hFF, 8'hFE);
    chk("ext0.lit", int'(diff_s), 8'hFE);
    step("extff",    8'hFF, 8'h00, 8'h00);
    chk("extff.lit", int'(diff_s), 8'hFF);
    step("tie_eq",   8'h40, 8'h40, 8'h40);
    step("b_tiny",   8'h80, 8'h00, 8'h7F);

    for (int i = 0; i < 16; i++) begin
      r = int'($urandom_range(255));
      a = int'($urandom_range(255));
      b = int'($urandom_range(255));
      step($sformatf("rnd%0d", i), r, a, b);
    end

    // Reset in the middle of a stream of results.
    @(negedge clk);
    reff = 8'h10; aa = 8'h90; bb = 8'h20;
    #1 rst_n = 1'b0;
    #1 chk_out("rst_mid", 0, 0);
    @(posedge clk); #1;
    chk_out("rst_mid_hold", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step("resume", 8'h10, 8'h90, 8'h20);

    for (int i = 0; i < 8; i++) begin
      r = int'($urandom_range(255));
      a = int'($urandom_range(255));
      b = int'($urandom_range(255));
      step($sformatf("rnd_post%0d", i), r, a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
